trivium_cipher: RTL and testbench



---
 rtl/trivium_cipher.sv | 73 +++++++
 tb/tb_trivium_cipher.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/trivium_cipher.sv
`default_nettype none
// ============================================================================
// Module   : trivium_cipher
// Brief    : Bit-serial Trivium keystream generator (80-bit key/IV, 288-bit
//            state) with internal warm-up before keystream output.
// Revision : 1.0 - initial release
// ============================================================================
module trivium_cipher #(
    parameter int WARMUP = 1152
) (
    output logic        s,
    input  logic [80:1] iv,
    input  logic [80:1] key,
    input  logic        rst,
    input  logic        clk,
    output logic        ks_valid
);

    localparam int                c_CW     = ($clog2(WARMUP + 1) > 11) ? $clog2(WARMUP + 1) : 11;
    localparam logic [c_CW-1:0]   c_WARMUP = c_CW'(WARMUP);

    // r_st[i] holds Trivium state bit si.
    logic [288:1]    r_st;
    logic [c_CW-1:0] r_cnt;
    logic            r_s;
    logic            r_valid;

    logic w_t1, w_t2, w_t3, w_z;
    logic w_n1, w_n2, w_n3;

    assign w_t1 = r_st[66]  ^ r_st[93];
    assign w_t2 = r_st[162] ^ r_st[177];
    assign w_t3 = r_st[243] ^ r_st[288];
    assign w_z  = w_t1 ^ w_t2 ^ w_t3;

    assign w_n1 = w_t1 ^ (r_st[91]  & r_st[92])  ^ r_st[171];
    assign w_n2 = w_t2 ^ (r_st[175] & r_st[176]) ^ r_st[264];
    assign w_n3 = w_t3 ^ (r_st[286] & r_st[287]) ^ r_st[69];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st[80:1]    <= key;
            r_st[93:81]   <= '0;
            r_st[173:94]  <= iv;
            r_st[285:174] <= '0;
            r_st[288:286] <= 3'b111;
            r_cnt         <= '0;
            r_s           <= 1'b0;
            r_valid       <= 1'b0;
        end else begin
            r_st[1]       <= w_n3;
            r_st[93:2]    <= r_st[92:1];
            r_st[94]      <= w_n1;
            r_st[177:95]  <= r_st[176:94];
            r_st[178]     <= w_n2;
            r_st[288:179] <= r_st[287:178];
            // Counter saturates at WARMUP so keystream runs indefinitely.
            if (r_cnt < c_WARMUP) begin
                r_cnt   <= r_cnt + 1'b1;
                r_s     <= 1'b0;
                r_valid <= 1'b0;
            end else begin
                r_s     <= w_z;
                r_valid <= 1'b1;
            end
        end
    end

    assign s        = r_s;
    assign ks_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_trivium_cipher.sv
`default_nettype none
// ============================================================================
// Module   : tb_trivium_cipher
// Brief    : Table-driven bench comparing trivium_cipher to a Trivium model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trivium_cipher;

    localparam int c_WARMUP = 1152;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [80:1] key = '0;
    logic [80:1] iv  = '0;
    logic        s;
    logic        ks_valid;

    int errors = 0;
    int checks = 0;

    trivium_cipher #(.WARMUP(c_WARMUP)) dut (
        .s        (s),
        .iv       (iv),
        .key      (key),
        .rst      (rst),
        .clk      (clk),
        .ks_valid (ks_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [80:1] key;
        logic [80:1] iv;
        int          nbits;
        bit          toggle;
        int          rst_edges;
        int          exp_first;
    } vec_t;

    // Reference model: whole-register shift, then feedback insertion.
    bit m [1:288];

    task automatic m_load(input logic [80:1] k, input logic [80:1] v);
        for (int i = 1; i <= 288; i++) m[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            m[i]      = k[i];
            m[93 + i] = v[i];
        end
        m[286] = 1'b1; m[287] = 1'b1; m[288] = 1'b1;
    endtask

    task automatic m_step(output bit z);
        bit a, b, c;
        a = m[66]  ^ m[93];
        b = m[162] ^ m[177];
        c = m[243] ^ m[288];
        z = a ^ b ^ c;
        a = a ^ (m[91]  & m[92])  ^ m[171];
        b = b ^ (m[175] & m[176]) ^ m[264];
        c = c ^ (m[286] & m[287]) ^ m[69];
        for (int i = 288; i > 1; i--) m[i] = m[i-1];
        m[1]   = c;
        m[94]  = a;
        m[178] = b;
    endtask

    task automatic m_gen(input logic [80:1] k, input logic [80:1] v, input int n,
                         output logic [511:0] ex);
        bit z;
        ex = '0;
        m_load(k, v);
        for (int i = 0; i < c_WARMUP; i++) m_step(z);
        for (int i = 0; i < n; i++) begin
            m_step(z);
            ex[i] = z;
        end
    endtask

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rnd80(output logic [80:1] r);
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        r = t[79:0];
    endtask

    // Reset (rst_edges edges, junk key before the last), then run WARMUP+n edges.
    task automatic run_vec(input vec_t v, input string tag, output logic [511:0] got);
        int warm_bad, drop, first;
        logic [80:1] r;
        got = '0; warm_bad = 0; drop = 0; first = -1;
        rst = 1'b1;
        for (int e = 0; e < v.rst_edges; e++) begin
            if (e == v.rst_edges - 1) key = v.key;
            else begin rnd80(r); key = r; end
            iv = v.iv;
            tick();
        end
        chk({tag, "_rst_s"}, 512'(s), 512'(0));
        chk({tag, "_rst_valid"}, 512'(ks_valid), 512'(0));
        rst = 1'b0;
        for (int e = 1; e <= c_WARMUP + v.nbits; e++) begin
            if (v.toggle) begin
                rnd80(r); key = r;
                rnd80(r); iv  = r;
            end
            tick();
            if (ks_valid === 1'b1 && first < 0) first = e;
            if (e <= c_WARMUP) begin
                if (s !== 1'b0 || ks_valid !== 1'b0) warm_bad++;
            end else begin
                if (ks_valid !== 1'b1) drop++;
                got[e - c_WARMUP - 1] = s;
            end
        end
        chk({tag, "_warmup_quiet"}, 512'(warm_bad), 512'(0));
        chk({tag, "_first_valid_edge"}, 512'(first), 512'(v.exp_first));
        chk({tag, "_valid_drops"}, 512'(drop), 512'(0));
    endtask

    initial begin
        vec_t        tbl [7];
        logic [511:0] got, ex;
        int          ones;

        tbl[0] = '{80'h0, 80'h0, 256, 1'b0, 1, c_WARMUP + 1};
        tbl[1] = '{80'h0123_4567_89AB_CDEF_F00D, 80'hDEAD_BEEF_CAFE_1234_5678, 512, 1'b0, 1, c_WARMUP + 1};
        tbl[2] = '{80'h8000_0000_0000_0000_0001, 80'h5A5A_A5A5_3C3C_C3C3_0FF0, 512, 1'b0, 1, c_WARMUP + 1};
        tbl[3] = '{80'hFEDC_BA98_7654_3210_1357, 80'h0000_0000_0000_0000_0001, 512, 1'b0, 1, c_WARMUP + 1};
        tbl[4] = '{80'hFFFF_FFFF_FFFF_FFFF_FFFF, 80'hFFFF_FFFF_FFFF_FFFF_FFFF, 256, 1'b0, 1, c_WARMUP + 1};
        tbl[5] = '{80'h0123_4567_89AB_CDEF_F00D, 80'hDEAD_BEEF_CAFE_1234_5678, 512, 1'b1, 1, c_WARMUP + 1};
        tbl[6] = '{80'h1111_2222_3333_4444_5555, 80'h9999_8888_7777_6666_0000, 256, 1'b0, 5, c_WARMUP + 1};

        for (int i = 0; i < 7; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_vec(tbl[i], tag, got);
            m_gen(tbl[i].key, tbl[i].iv, tbl[i].nbits, ex);
            chk({tag, "_keystream"}, got, ex);
            if (i == 4) begin
                ones = $countones(got[255:0]);
                chk("ones_window_mixed", 512'(ones > 0 && ones < 256), 512'(1));
            end
        end

        // Reset during warm-up at edge 600, then a fresh run must match.
        rst = 1'b1; key = tbl[2].key; iv = tbl[2].iv;
        tick();
        rst = 1'b0;
        for (int e = 0; e < 600; e++) tick();
        chk("mid_warmup_valid_low", 512'(ks_valid), 512'(0));
        run_vec(tbl[2], "after_warm_rst", got);
        m_gen(tbl[2].key, tbl[2].iv, tbl[2].nbits, ex);
        chk("after_warm_rst_keystream", got, ex);

        // Reset at keystream bit 50: outputs must drop on that edge.
        rst = 1'b1; key = tbl[1].key; iv = tbl[1].iv;
        tick();
        rst = 1'b0;
        for (int e = 0; e < c_WARMUP + 50; e++) tick();
        chk("mid_stream_valid_high", 512'(ks_valid), 512'(1));
        run_vec(tbl[3], "after_ks_rst", got);
        m_gen(tbl[3].key, tbl[3].iv, tbl[3].nbits, ex);
        chk("after_ks_rst_keystream", got, ex);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
